// File: rtl/pulse_gen_pkg.sv
// Shared types and default constants for the pulse width generator family.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_MIN_HIGH = 2;
    localparam int DEF_MAX_HIGH = 6;
    localparam int DEF_MIN_LOW  = 1;
    localparam int LEN_W        = 3;
    // Shared down-counter width: must hold MAX_HIGH-1 and MIN_LOW-2.
    localparam int CNT_W        = 8;

endpackage

// File: rtl/pulse_len_clamp.sv
// Clamps a requested pulse length into [MIN_HIGH, MAX_HIGH] and flags out-of-range requests.
module pulse_len_clamp
    import pulse_gen_pkg::*;
#(
    parameter int MIN_HIGH = DEF_MIN_HIGH,
    parameter int MAX_HIGH = DEF_MAX_HIGH
) (
    input  logic [LEN_W-1:0] len_in,
    output logic [LEN_W-1:0] len_out,
    output logic             out_of_range
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_HIGH);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_HIGH);

    logic below;
    logic above;

    always_comb begin
        below        = (len_in < MIN_L);
        above        = (len_in > MAX_L);
        out_of_range = below | above;
        len_out      = len_in;
        if (below) begin
            len_out = MIN_L;
        end else if (above) begin
            len_out = MAX_L;
        end
    end

endmodule

// File: rtl/pulse_width_gen.sv
// Single-pulse generator: accepts a length request, drives a registered high pulse, then a low gap.
// Define PULSE_WIDTH_GEN_ASSERT_EN to compile in protocol assertions on sig/done.
module pulse_width_gen
    import pulse_gen_pkg::*;
#(
    parameter int MIN_HIGH = DEF_MIN_HIGH,
    parameter int MAX_HIGH = DEF_MAX_HIGH,
    parameter int MIN_LOW  = DEF_MIN_LOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    output logic             sig,
    output logic             done,
    output logic             clamped,
    output logic [7:0]       pulse_count
);

    localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'((MIN_LOW >= 2) ? (MIN_LOW - 2) : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_q, sig_d;
    logic             done_q, done_d;
    logic             clamped_q, clamped_d;
    logic [7:0]       count_q, count_d;

    logic [LEN_W-1:0] eff_len;
    logic             len_oor;
    logic             accept;

    pulse_len_clamp #(
        .MIN_HIGH (MIN_HIGH),
        .MAX_HIGH (MAX_HIGH)
    ) u_clamp (
        .len_in       (req_len),
        .len_out      (eff_len),
        .out_of_range (len_oor)
    );

    // Gating with rst keeps the generator from looking ready while held in reset.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sig_d     = sig_q;
        done_d    = 1'b0;
        clamped_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = HIGH;
                    sig_d     = 1'b1;
                    clamped_d = len_oor;
                    cnt_d     = CNT_W'(eff_len) - CNT_W'(1);
                end
            end
            HIGH: begin
                // cnt_q counts the high cycles still to come after this one.
                if (cnt_q == '0) begin
                    sig_d   = 1'b0;
                    done_d  = 1'b1;
                    count_d = count_q + 8'd1;
                    if (MIN_LOW <= 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sig_q     <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sig_q     <= sig_d;
            done_q    <= done_d;
            clamped_q <= clamped_d;
            count_q   <= count_d;
        end
    end

    assign sig         = sig_q;
    assign done        = done_q;
    assign clamped     = clamped_q;
    assign pulse_count = count_q;

`ifdef PULSE_WIDTH_GEN_ASSERT_EN
    a_high_min: assert property (@(posedge clk) disable iff (rst)
        $rose(sig_q) |-> sig_q [* MIN_HIGH]);
    a_high_max: assert property (@(posedge clk) disable iff (rst)
        $rose(sig_q) |-> ##[1:MAX_HIGH] !sig_q);
    a_low_min: assert property (@(posedge clk) disable iff (rst)
        $fell(sig_q) |-> !sig_q [* MIN_LOW]);
    a_done_fall: assert property (@(posedge clk) disable iff (rst)
        done_q |-> $fell(sig_q));
`endif

endmodule

// File: tb/tb_pulse_width_gen.sv
// Bench for pulse_width_gen: per-cycle timeline model plus directed literal checks.
module tb_pulse_width_gen;

    localparam int MIN_HIGH = 2;
    localparam int MAX_HIGH = 6;
    localparam int MIN_LOW  = 1;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_len;
    logic       sig;
    logic       done;
    logic       clamped;
    logic [7:0] pulse_count;

    int n_compared;
    int n_mismatched;

    pulse_width_gen #(
        .MIN_HIGH (MIN_HIGH),
        .MAX_HIGH (MAX_HIGH),
        .MIN_LOW  (MIN_LOW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_len     (req_len),
        .sig         (sig),
        .done        (done),
        .clamped     (clamped),
        .pulse_count (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a pulse accepted at edge p_start is high after edges
    // p_start..p_start+p_n-1, done after edge p_start+p_n, and the next accept
    // is allowed from edge p_start+p_n+MIN_LOW on.
    int   cyc;
    int   next_free;
    int   p_start;
    int   p_n;
    bit   p_clamp;
    bit   p_active;
    int   m_count;

    function automatic int eff_width(input int len);
        if (len < MIN_HIGH) return MIN_HIGH;
        if (len > MAX_HIGH) return MAX_HIGH;
        return len;
    endfunction

    always @(posedge clk) begin
        int e_sig, e_done, e_clamp, e_ready;
        cyc++;
        if (rst) begin
            p_active  = 0;
            next_free = 0;
            m_count   = 0;
            e_sig = 0; e_done = 0; e_clamp = 0; e_ready = 0;
        end else begin
            if (req_valid && cyc >= next_free) begin
                p_start   = cyc;
                p_n       = eff_width(int'(req_len));
                p_clamp   = (int'(req_len) < MIN_HIGH) || (int'(req_len) > MAX_HIGH);
                p_active  = 1;
                next_free = cyc + p_n + MIN_LOW;
            end
            e_sig   = (p_active && cyc >= p_start && cyc < p_start + p_n) ? 1 : 0;
            e_done  = (p_active && cyc == p_start + p_n) ? 1 : 0;
            e_clamp = (p_active && cyc == p_start && p_clamp) ? 1 : 0;
            if (e_done == 1) m_count = (m_count + 1) % 256;
            e_ready = (cyc + 1 >= next_free) ? 1 : 0;
        end
        #1;
        chk("mon_sig",     int'(sig),         e_sig);
        chk("mon_done",    int'(done),        e_done);
        chk("mon_clamped", int'(clamped),     e_clamp);
        chk("mon_count",   int'(pulse_count), m_count);
        chk("mon_ready",   int'(req_ready),   rst ? 0 : e_ready);
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 0, 1);
    endtask

    // Issues one request and measures the high run at negedges.
    task automatic run_pulse(input logic [2:0] len, input int exp_high,
                             input int exp_clamp, input string tag);
        int hi;
        wait_ready();
        req_valid = 1'b1;
        req_len   = len;
        @(posedge clk);
        #1;
        chk({tag, "_clamped"}, int'(clamped), exp_clamp);
        @(negedge clk);
        req_valid = 1'b0;
        req_len   = 3'($urandom_range(0, 7));
        hi = 0;
        while (sig && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        chk({tag, "_high"}, hi, exp_high);
        chk({tag, "_done"}, int'(done), 1);
    endtask

    initial begin
        logic [15:0] hist;
        logic [9:0]  hist10;
        int          base;

        n_compared   = 0;
        n_mismatched = 0;
        cyc = 0; next_free = 0; p_active = 0; m_count = 0;
        p_start = 0; p_n = 0; p_clamp = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_len   = 3'd0;
        #2 rst = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_sig",   int'(sig),         0);
        chk("rst_count", int'(pulse_count), 0);
        chk("rst_ready", int'(req_ready),   0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", int'(req_ready), 1);

        run_pulse(3'd2, 2, 0, "len2");
        chk("len2_count", int'(pulse_count), 1);
        run_pulse(3'd6, 6, 0, "len6");
        run_pulse(3'd1, 2, 1, "len1");
        run_pulse(3'd7, 6, 1, "len7");
        run_pulse(3'd0, 2, 1, "len0");
        chk("after5_count", int'(pulse_count), 5);

        // Back-to-back: four accepts at t, t+4, t+8, t+12 with valid held.
        base = int'(pulse_count);
        wait_ready();
        req_valid = 1'b1;
        req_len   = 3'd3;
        @(posedge clk);
        hist = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hist = {hist[14:0], sig};
            if (i == 12) req_valid = 1'b0;
        end
        chk("b2b_pattern", int'(hist), 16'hEEEE);
        chk("b2b_count", int'(pulse_count) - base, 4);

        // Valid toggled while busy must not stretch or restart the pulse.
        wait_ready();
        req_valid = 1'b1;
        req_len   = 3'd5;
        @(posedge clk);
        hist10 = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hist10    = {hist10[8:0], sig};
            req_len   = 3'd7;
            req_valid = (k == 1 || k == 3);
        end
        req_valid = 1'b0;
        chk("toggle_pattern", int'(hist10), 10'b1111100000);

        // Reset during the 3rd high cycle of a 5-cycle pulse.
        wait_ready();
        req_valid = 1'b1;
        req_len   = 3'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_sig", int'(sig), 1);
        rst = 1'b1;
        #1;
        chk("async_sig",   int'(sig),         0);
        chk("async_done",  int'(done),        0);
        chk("async_count", int'(pulse_count), 0);
        chk("async_ready", int'(req_ready),   0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(req_ready), 1);
        repeat (6) @(negedge clk);
        chk("post_rst_count", int'(pulse_count), 0);

        // 256 pulses of width 2 at period 3: count passes 255 then wraps to 0.
        wait_ready();
        req_valid = 1'b1;
        req_len   = 3'd2;
        @(posedge clk);
        repeat (765) @(posedge clk);
        #1;
        chk("wrap_255", int'(pulse_count), 255);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_0", int'(pulse_count), 0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, compared %0d", n_compared);
        $fatal(1, "timeout");
    end

endmodule
